// File: rtl/minisys_input_conditioner.sv
// Input conditioner for slide switches and push buttons.
// Provides two-flop synchronization, debouncing, and change/press/release pulses.
module minisys_input_conditioner #(
  parameter int unsigned SW_WIDTH        = 24,
  parameter int unsigned BTN_WIDTH       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 Minisys_Clock,
  input  logic                 Minisys_Rst_n,
  input  logic [SW_WIDTH-1:0]  Minisys_Switches,
  input  logic [BTN_WIDTH-1:0] Minisys_Button,
  output logic [SW_WIDTH-1:0]  sw_stable,
  output logic                 sw_changed,
  output logic [BTN_WIDTH-1:0] btn_stable,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sw_meta;
  logic [SW_WIDTH-1:0]  sw_sync;
  logic [SW_WIDTH-1:0]  sw_prev;
  logic [BTN_WIDTH-1:0] btn_meta;
  logic [BTN_WIDTH-1:0] btn_sync;

  // Two-flop synchronizers plus the previous-sample copy used for switch bounce detection.
  always_ff @(posedge Minisys_Clock or negedge Minisys_Rst_n) begin
    if (!Minisys_Rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      sw_prev  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= Minisys_Switches;
      sw_sync  <= sw_meta;
      sw_prev  <= sw_sync;
      btn_meta <= Minisys_Button;
      btn_sync <= btn_meta;
    end
  end

  // Group debounce: the whole vector must hold unchanged and differ from the stable value.
  logic [CNT_W-1:0]    sw_cnt_q;
  logic [CNT_W-1:0]    sw_cnt_d;
  logic [SW_WIDTH-1:0] sw_stable_d;
  logic                sw_changed_d;

  always_comb begin
    sw_cnt_d     = sw_cnt_q;
    sw_stable_d  = sw_stable;
    sw_changed_d = 1'b0;
    if ((sw_sync != sw_prev) || (sw_sync == sw_stable)) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == CNT_LAST) begin
      sw_cnt_d     = '0;
      sw_stable_d  = sw_sync;
      sw_changed_d = 1'b1;
    end else begin
      sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Minisys_Clock or negedge Minisys_Rst_n) begin
    if (!Minisys_Rst_n) begin
      sw_cnt_q   <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_cnt_q   <= sw_cnt_d;
      sw_stable  <= sw_stable_d;
      sw_changed <= sw_changed_d;
    end
  end

  // Independent per-button debounce with edge pulses aligned to the new stable level.
  for (genvar i = 0; i < int'(BTN_WIDTH); i++) begin : gen_btn
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    always_comb begin
      cnt_d     = cnt_q;
      stable_d  = stable_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (btn_sync[i] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        stable_d  = btn_sync[i];
        press_d   = btn_sync[i];
        release_d = ~btn_sync[i];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge Minisys_Clock or negedge Minisys_Rst_n) begin
      if (!Minisys_Rst_n) begin
        cnt_q     <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        stable_q  <= stable_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_stable[i]  = stable_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_minisys_input_conditioner.sv
// Directed self-checking bench for minisys_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_minisys_input_conditioner;

  localparam int unsigned SW_W  = 24;
  localparam int unsigned BTN_W = 5;

  logic             clk;
  logic             rst_n;
  logic [SW_W-1:0]  switches;
  logic [BTN_W-1:0] button;
  logic [SW_W-1:0]  sw_stable;
  logic             sw_changed;
  logic [BTN_W-1:0] btn_stable;
  logic [BTN_W-1:0] btn_press;
  logic [BTN_W-1:0] btn_release;

  int checks;
  int errors;

  minisys_input_conditioner #(
    .SW_WIDTH(SW_W),
    .BTN_WIDTH(BTN_W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Minisys_Clock(clk),
    .Minisys_Rst_n(rst_n),
    .Minisys_Switches(switches),
    .Minisys_Button(button),
    .sw_stable(sw_stable),
    .sw_changed(sw_changed),
    .btn_stable(btn_stable),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    switches = '1;
    button   = '1;
    tick(3);
    checks++;
    if ({sw_stable, sw_changed, btn_stable, btn_press, btn_release} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sw=%h chg=%b bs=%b bp=%b br=%b, want all 0",
               sw_stable, sw_changed, btn_stable, btn_press, btn_release);
    end
    switches = '0;
    button   = '0;
    rst_n    = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      checks++;
      if ({sw_stable, sw_changed, btn_stable, btn_press, btn_release} !== '0) begin
        errors++;
        $display("FAIL post_reset_idle e=%0d: got sw=%h chg=%b bs=%b bp=%b br=%b, want all 0",
                 e, sw_stable, sw_changed, btn_stable, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_clean_press();
    button = 5'b00001;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      checks++;
      if (btn_stable !== ((e >= 6) ? 5'b00001 : 5'b00000) ||
          btn_press !== ((e == 6) ? 5'b00001 : 5'b00000) || btn_release !== 5'b00000) begin
        errors++;
        $display("FAIL clean_press e=%0d: got bs=%b bp=%b br=%b", e, btn_stable, btn_press, btn_release);
      end
    end
    button = 5'b00000;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      checks++;
      if (btn_stable !== ((e >= 6) ? 5'b00000 : 5'b00001) ||
          btn_release !== ((e == 6) ? 5'b00001 : 5'b00000) || btn_press !== 5'b00000) begin
        errors++;
        $display("FAIL clean_release e=%0d: got bs=%b bp=%b br=%b", e, btn_stable, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_bouncy_press();
    for (int c = 0; c < 20; c++) begin
      button[1] = ((c / 2) % 2 == 0);
      tick(1);
      checks++;
      if (btn_stable !== 5'b0 || btn_press !== 5'b0 || btn_release !== 5'b0) begin
        errors++;
        $display("FAIL bouncy_quiet c=%0d: got bs=%b bp=%b br=%b", c, btn_stable, btn_press, btn_release);
      end
    end
    button[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      checks++;
      if (btn_stable !== ((e >= 6) ? 5'b00010 : 5'b00000) ||
          btn_press !== ((e == 6) ? 5'b00010 : 5'b00000)) begin
        errors++;
        $display("FAIL bouncy_press e=%0d: got bs=%b bp=%b", e, btn_stable, btn_press);
      end
    end
    button = 5'b0;
    tick(8);
    checks++;
    if (btn_stable !== 5'b0) begin
      errors++;
      $display("FAIL bouncy_settle: got bs=%b want 00000", btn_stable);
    end
  endtask

  task automatic test_switch_change();
    switches = 24'h200000;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      checks++;
      if (sw_stable !== ((e >= 7) ? 24'h200000 : 24'h000000) || sw_changed !== (e == 7)) begin
        errors++;
        $display("FAIL switch_change e=%0d: got sw=%h chg=%b", e, sw_stable, sw_changed);
      end
    end
  endtask

  task automatic test_switch_restart();
    switches = 24'h000003;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      checks++;
      if (sw_stable !== 24'h200000 || sw_changed !== 1'b0) begin
        errors++;
        $display("FAIL switch_restart_pre e=%0d: got sw=%h chg=%b", e, sw_stable, sw_changed);
      end
    end
    switches = 24'h010003;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      checks++;
      if (sw_stable !== ((e >= 7) ? 24'h010003 : 24'h200000) || sw_changed !== (e == 7)) begin
        errors++;
        $display("FAIL switch_restart e=%0d: got sw=%h chg=%b", e, sw_stable, sw_changed);
      end
    end
  endtask

  task automatic test_mid_reset();
    button = 5'b01000;
    tick(3);
    rst_n = 1'b0;
    for (int e = 0; e <= 2; e++) begin
      if (e > 0) tick(1);
      else #1;
      checks++;
      if ({sw_stable, sw_changed, btn_stable, btn_press, btn_release} !== '0) begin
        errors++;
        $display("FAIL mid_reset_hold e=%0d: got sw=%h chg=%b bs=%b bp=%b br=%b",
                 e, sw_stable, sw_changed, btn_stable, btn_press, btn_release);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      checks++;
      if (btn_stable !== ((e >= 6) ? 5'b01000 : 5'b00000) ||
          btn_press !== ((e == 6) ? 5'b01000 : 5'b00000) ||
          sw_stable !== ((e >= 7) ? 24'h010003 : 24'h000000) || sw_changed !== (e == 7)) begin
        errors++;
        $display("FAIL mid_reset_requal e=%0d: got bs=%b bp=%b sw=%h chg=%b",
                 e, btn_stable, btn_press, sw_stable, sw_changed);
      end
    end
  endtask

  task automatic test_simultaneous();
    button = 5'b00000;
    tick(8);
    button = 5'b11000;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      checks++;
      if (btn_press !== ((e == 6) ? 5'b11000 : 5'b00000) || btn_release !== 5'b0 ||
          btn_stable !== ((e >= 6) ? 5'b11000 : 5'b00000)) begin
        errors++;
        $display("FAIL simul_press e=%0d: got bs=%b bp=%b br=%b", e, btn_stable, btn_press, btn_release);
      end
    end
    button = 5'b00000;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      checks++;
      if (btn_release !== ((e == 6) ? 5'b11000 : 5'b00000) || btn_press !== 5'b0 ||
          btn_stable !== ((e >= 6) ? 5'b00000 : 5'b11000)) begin
        errors++;
        $display("FAIL simul_release e=%0d: got bs=%b bp=%b br=%b", e, btn_stable, btn_press, btn_release);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    switches = '0;
    button   = '0;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_switch_change();
    test_switch_restart();
    test_mid_reset();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
